mdu_sequencer: RTL and testbench

//  Arbiter/sequencer for the single shared iterative multiply/divide unit (MDU).

---
 rtl/mdu_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Round-robin arbiter/sequencer feeding one shared iterative MDU; optional div/rem fuse cache via MDU_DIVREM_FUSE_EN.
// Latency: grant -> ISSUE -> WAIT (>=1 cycle) -> RESP, minimum 4 cycles per op; fuse hit goes grant -> RESP.
// Backpressure: req_ready only in IDLE; the result is held in RESP until wb_ready; flush overrides everything.
module mdu_sequencer #(
    parameter int NREQ = 4,
    parameter int XLEN = 64,
    parameter int TAGW = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [4*NREQ-1:0]      req_ctl,
    input  logic [XLEN*NREQ-1:0]   req_a,
    input  logic [XLEN*NREQ-1:0]   req_b,
    input  logic [TAGW*NREQ-1:0]   req_tag,
    output logic [NREQ-1:0]        req_ready,
    output logic                   mdu_start,
    output logic [3:0]             mdu_ctl,
    output logic [XLEN-1:0]        mdu_a,
    output logic [XLEN-1:0]        mdu_b,
    input  logic                   mdu_done,
    input  logic [XLEN-1:0]        mdu_res,
    input  logic [XLEN-1:0]        mdu_alt,
    output logic                   wb_valid,
    output logic [TAGW-1:0]        wb_tag,
    output logic [XLEN-1:0]        wb_data,
    input  logic                   wb_ready,
    output logic                   busy
);

    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW1 = PW + 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] RESP  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;

    logic [2:0]      state;
    logic [PW-1:0]   rrPtr;
    logic [PW-1:0]   grantIdx;
    logic [PW-1:0]   nextPtr;
    logic [PW1-1:0]  probe;
    logic            anyValid;
    logic            grantOk;

    logic [3:0]      slotCtl [NREQ];
    logic [XLEN-1:0] slotA   [NREQ];
    logic [XLEN-1:0] slotB   [NREQ];
    logic [TAGW-1:0] slotTag [NREQ];

    logic [3:0]      gCtl;
    logic [XLEN-1:0] gA;
    logic [XLEN-1:0] gB;
    logic [TAGW-1:0] gTag;

    logic            fuseHit;
    logic [XLEN-1:0] fuseData;

    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        assign slotCtl[i] = req_ctl[4*i +: 4];
        assign slotA[i]   = req_a[XLEN*i +: XLEN];
        assign slotB[i]   = req_b[XLEN*i +: XLEN];
        assign slotTag[i] = req_tag[TAGW*i +: TAGW];
    end

    // Scan from rrPtr upward with wrap; descending loop lets the nearest slot win.
    always_comb begin
        anyValid = 1'b0;
        grantIdx = '0;
        probe    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            probe = {1'b0, rrPtr} + PW1'(k);
            if (probe >= PW1'(NREQ)) begin
                probe = probe - PW1'(NREQ);
            end
            if (req_valid[probe[PW-1:0]]) begin
                anyValid = 1'b1;
                grantIdx = probe[PW-1:0];
            end
        end
    end

    assign nextPtr = (grantIdx == PW'(NREQ - 1)) ? '0 : grantIdx + PW'(1);
    assign grantOk = (state == IDLE) && anyValid && !flush;

    assign gCtl = slotCtl[grantIdx];
    assign gA   = slotA[grantIdx];
    assign gB   = slotB[grantIdx];
    assign gTag = slotTag[grantIdx];

    always_comb begin
        req_ready = '0;
        if (grantOk && !rst) begin
            req_ready[grantIdx] = 1'b1;
        end
    end

    assign mdu_start = (state == ISSUE) && !flush;
    assign wb_valid  = (state == RESP);
    assign busy      = (state != IDLE);

`ifdef MDU_DIVREM_FUSE_EN
    logic            cacheVld;
    logic [XLEN-1:0] cacheA;
    logic [XLEN-1:0] cacheB;
    logic [XLEN-1:0] cacheQ;
    logic [XLEN-1:0] cacheR;
    logic            cacheW;
    logic            cacheU;

    assign fuseHit  = gCtl[3] && cacheVld && (gA == cacheA) && (gB == cacheB)
                      && (gCtl[2] == cacheW) && (gCtl[0] == cacheU);
    assign fuseData = gCtl[1] ? cacheR : cacheQ;

    // Only a clean div completion refreshes the cache; flush leaves it intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cacheVld <= 1'b0;
            cacheA   <= '0;
            cacheB   <= '0;
            cacheQ   <= '0;
            cacheR   <= '0;
            cacheW   <= 1'b0;
            cacheU   <= 1'b0;
        end else if ((state == WAIT) && mdu_done && !flush && mdu_ctl[3]) begin
            cacheVld <= 1'b1;
            cacheA   <= mdu_a;
            cacheB   <= mdu_b;
            cacheW   <= mdu_ctl[2];
            cacheU   <= mdu_ctl[0];
            cacheQ   <= mdu_ctl[1] ? mdu_alt : mdu_res;
            cacheR   <= mdu_ctl[1] ? mdu_res : mdu_alt;
        end
    end
`else
    logic unusedAlt;
    assign unusedAlt = ^mdu_alt;
    assign fuseHit   = 1'b0;
    assign fuseData  = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rrPtr   <= '0;
            mdu_ctl <= '0;
            mdu_a   <= '0;
            mdu_b   <= '0;
            wb_tag  <= '0;
            wb_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyValid && !flush) begin
                        mdu_ctl <= gCtl;
                        mdu_a   <= gA;
                        mdu_b   <= gB;
                        wb_tag  <= gTag;
                        rrPtr   <= nextPtr;
                        if (fuseHit) begin
                            wb_data <= fuseData;
                            state   <= RESP;
                        end else begin
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: state <= flush ? IDLE : WAIT;
                WAIT: begin
                    // The MDU cannot be aborted: a flush before done must drain it.
                    if (flush) begin
                        state <= mdu_done ? IDLE : DRAIN;
                    end else if (mdu_done) begin
                        wb_data <= mdu_res;
                        state   <= RESP;
                    end
                end
                DRAIN: begin
                    if (mdu_done) begin
                        state <= IDLE;
                    end
                end
                RESP: begin
                    if (flush || wb_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer with a behavioural MDU and a writeback scoreboard.
module tb_mdu_sequencer;

    typedef struct {
        logic [4:0]  tag;
        logic [63:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [3:0]   req_valid;
    logic [15:0]  req_ctl;
    logic [255:0] req_a;
    logic [255:0] req_b;
    logic [19:0]  req_tag;
    logic [3:0]   req_ready;
    logic         mdu_start;
    logic [3:0]   mdu_ctl;
    logic [63:0]  mdu_a;
    logic [63:0]  mdu_b;
    logic         mdu_done;
    logic [63:0]  mdu_res;
    logic [63:0]  mdu_alt;
    logic         wb_valid;
    logic [4:0]   wb_tag;
    logic [63:0]  wb_data;
    logic         wb_ready;
    logic         busy;

    int   tests = 0;
    int   fails = 0;
    int   startCnt = 0;
    int   wbVldCnt = 0;
    int   mduLat = 1;
    int   grantLog[$];
    exp_t expQ[$];

    logic [3:0]  mCtl;
    logic [63:0] mA;
    logic [63:0] mB;

    mdu_sequencer dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ctl(req_ctl), .req_a(req_a), .req_b(req_b),
        .req_tag(req_tag), .req_ready(req_ready),
        .mdu_start(mdu_start), .mdu_ctl(mdu_ctl), .mdu_a(mdu_a), .mdu_b(mdu_b),
        .mdu_done(mdu_done), .mdu_res(mdu_res), .mdu_alt(mdu_alt),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_ready(wb_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Behavioural MDU: done pulses mduLat cycles after the start cycle.
    initial begin
        mdu_done = 1'b0;
        mdu_res  = '0;
        mdu_alt  = '0;
        forever begin
            @(negedge clk);
            if (mdu_start === 1'b1 && rst === 1'b0) begin
                mCtl = mdu_ctl;
                mA   = mdu_a;
                mB   = mdu_b;
                repeat (mduLat) @(posedge clk);
                #2;
                if (mCtl[3]) begin
                    mdu_res = mCtl[1] ? (mA % mB) : (mA / mB);
                    mdu_alt = mCtl[1] ? (mA / mB) : (mA % mB);
                end else begin
                    mdu_res = mA * mB;
                    mdu_alt = '0;
                end
                mdu_done = 1'b1;
                @(posedge clk);
                #2 mdu_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst === 1'b0) begin
            if (req_ready != 4'b0) begin
                chk("grant_onehot", 64'($countones(req_ready)), 64'd1);
                for (int i = 0; i < 4; i++) begin
                    if (req_ready[i]) grantLog.push_back(i);
                end
            end
            if (mdu_start) startCnt++;
            if (wb_valid) wbVldCnt++;
            if (wb_valid && wb_ready) begin
                if (expQ.size() == 0) begin
                    chk("wb_unexpected", 64'(wb_tag), 64'h1f_dead);
                end else begin
                    e = expQ.pop_front();
                    chk("wb_tag", 64'(wb_tag), 64'(e.tag));
                    chk("wb_data", wb_data, e.data);
                end
            end
        end
    end

    task automatic setSlot(input int s, input logic [3:0] c, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] t);
        req_ctl[4*s +: 4]  = c;
        req_a[64*s +: 64]  = a;
        req_b[64*s +: 64]  = b;
        req_tag[5*s +: 5]  = t;
    endtask

    task automatic pushExp(input logic [4:0] t, input logic [63:0] d);
        exp_t e;
        e.tag  = t;
        e.data = d;
        expQ.push_back(e);
    endtask

    task automatic waitGrant(input int slot);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready != 4'b0) break;
        end
        chk("grant_slot", 64'(req_ready), 64'(1 << slot));
        @(posedge clk);
        #1 req_valid[slot] = 1'b0;
    endtask

    task automatic waitGrants(input int n);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (grantLog.size() >= n) break;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!busy && expQ.size() == 0) break;
        end
        chk("drain_queue_empty", 64'(expQ.size()), 64'd0);
        chk("drain_idle", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int st0;
        int wbv0;
        int ordA[5];
        int ordB[4];
        ordA = '{0, 1, 2, 3, 0};
        ordB = '{0, 1, 3, 0};

        rst = 1'b1; flush = 1'b0; req_valid = 4'hf; req_ctl = '0; req_a = '0; req_b = '0;
        req_tag = '0; wb_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_mdu_start", 64'(mdu_start), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_wb_tag", 64'(wb_tag), 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        chk("rst_mdu_a", mdu_a, 64'd0);
        chk("rst_mdu_ctl", 64'(mdu_ctl), 64'd0);
        req_valid = '0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Single MUL through the MDU
        mduLat = 3;
        setSlot(0, 4'b0000, 64'd6, 64'd7, 5'd3);
        pushExp(5'd3, 64'd42);
        st0 = startCnt;
        req_valid[0] = 1'b1;
        waitGrant(0);
        @(negedge clk);
        chk("t1_ready_one_cycle", 64'(req_ready), 64'd0);
        chk("t1_start", 64'(mdu_start), 64'd1);
        chk("t1_mdu_a", mdu_a, 64'd6);
        chk("t1_mdu_b", mdu_b, 64'd7);
        drain();
        chk("t1_start_count", 64'(startCnt - st0), 64'd1);

        // Round-robin, all slots valid
        doReset();
        mduLat = 1;
        for (int i = 0; i < 4; i++) setSlot(i, 4'b0000, 64'(i + 2), 64'd10, 5'(8 + i));
        for (int i = 0; i < 5; i++) pushExp(5'(8 + (i % 4)), 64'(((i % 4) + 2) * 10));
        grantLog.delete();
        req_valid = 4'hf;
        waitGrants(5);
        req_valid = '0;
        drain();
        chk("t2a_grants", 64'(grantLog.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            chk("t2a_order", 64'((i < grantLog.size()) ? grantLog[i] : 99), 64'(ordA[i]));

        // Round-robin with slot 2 idle
        doReset();
        for (int i = 0; i < 4; i++) pushExp(5'(8 + ordB[i]), 64'((ordB[i] + 2) * 10));
        grantLog.delete();
        req_valid = 4'b1011;
        waitGrants(4);
        req_valid = '0;
        drain();
        chk("t2b_grants", 64'(grantLog.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            chk("t2b_order", 64'((i < grantLog.size()) ? grantLog[i] : 99), 64'(ordB[i]));

        // Writeback backpressure
        setSlot(1, 4'b0000, 64'd5, 64'd9, 5'd17);
        pushExp(5'd17, 64'd45);
        wb_ready = 1'b0;
        req_valid = 4'b0010;
        waitGrant(1);
        setSlot(3, 4'b0000, 64'd3, 64'd3, 5'd21);
        pushExp(5'd21, 64'd9);
        req_valid[3] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wb_valid) break;
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("t3_wb_valid", 64'(wb_valid), 64'd1);
            chk("t3_wb_tag", 64'(wb_tag), 64'd17);
            chk("t3_wb_data", wb_data, 64'd45);
            chk("t3_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1 wb_ready = 1'b1;
        waitGrant(3);
        drain();

        // Flush in WAIT -> drain, next grant only after done
        mduLat = 3;
        setSlot(0, 4'b0000, 64'd2, 64'd2, 5'd1);
        st0 = startCnt;
        wbv0 = wbVldCnt;
        req_valid = 4'b0001;
        waitGrant(0);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        setSlot(1, 4'b0000, 64'd4, 64'd4, 5'd2);
        pushExp(5'd2, 64'd16);
        req_valid[1] = 1'b1;
        @(negedge clk);
        chk("t4_drain_busy", 64'(busy), 64'd1);
        chk("t4_drain_ready", 64'(req_ready), 64'd0);
        chk("t4_drain_wb", 64'(wb_valid), 64'd0);
        @(negedge clk);
        chk("t4_done_cycle_ready", 64'(req_ready), 64'd0);
        waitGrant(1);
        drain();
        chk("t4_wb_count", 64'(wbVldCnt - wbv0), 64'd1);
        chk("t4_start_count", 64'(startCnt - st0), 64'd2);

        // Flush in ISSUE, then flush in IDLE blocks grant
        setSlot(2, 4'b0000, 64'd3, 64'd5, 5'd6);
        st0 = startCnt;
        req_valid = 4'b0100;
        waitGrant(2);
        flush = 1'b1;
        @(negedge clk);
        chk("t4b_no_start", 64'(mdu_start), 64'd0);
        @(posedge clk);
        #1;
        setSlot(0, 4'b0000, 64'd1, 64'd1, 5'd7);
        req_valid[0] = 1'b1;
        @(negedge clk);
        chk("t4b_idle_after_flush", 64'(busy), 64'd0);
        chk("t4b_flush_blocks_grant", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        pushExp(5'd7, 64'd1);
        waitGrant(0);
        drain();
        chk("t4b_start_count", 64'(startCnt - st0), 64'd1);

        // Reset during WAIT, late done ignored
        mduLat = 4;
        setSlot(3, 4'b0000, 64'd9, 64'd9, 5'd9);
        wbv0 = wbVldCnt;
        req_valid = 4'b1000;
        waitGrant(3);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_wb_valid", 64'(wb_valid), 64'd0);
        chk("t5_mdu_start", 64'(mdu_start), 64'd0);
        chk("t5_mdu_a", mdu_a, 64'd0);
        chk("t5_mdu_b", mdu_b, 64'd0);
        chk("t5_wb_tag", 64'(wb_tag), 64'd0);
        chk("t5_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("t5_no_late_wb", 64'(wbVldCnt - wbv0), 64'd0);
        chk("t5_idle", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // DIV then REM of the same operands
        mduLat = 2;
        setSlot(0, 4'b1000, 64'd100, 64'd7, 5'd4);
        pushExp(5'd4, 64'd14);
        st0 = startCnt;
        req_valid = 4'b0001;
        waitGrant(0);
        drain();
        setSlot(0, 4'b1010, 64'd100, 64'd7, 5'd5);
        pushExp(5'd5, 64'd2);
        req_valid = 4'b0001;
        waitGrant(0);
        @(negedge clk);
`ifdef MDU_DIVREM_FUSE_EN
        chk("t6_fuse_wb_valid", 64'(wb_valid), 64'd1);
        chk("t6_fuse_wb_data", wb_data, 64'd2);
        chk("t6_fuse_no_start", 64'(mdu_start), 64'd0);
        drain();
        chk("t6_start_count", 64'(startCnt - st0), 64'd1);
`else
        chk("t6_start", 64'(mdu_start), 64'd1);
        chk("t6_wb_valid", 64'(wb_valid), 64'd0);
        drain();
        chk("t6_start_count", 64'(startCnt - st0), 64'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
